// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle RV32 control path: FSM state
// encoding, ALU operation codes, opcode/funct3 values, datapath mux
// select codes and the branch-condition evaluator.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALU_WB   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_LD_WB    = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Datapath mux select codes
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC  = 2'b10;
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] PC_SRC_ALU   = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] WB_ALUOUT    = 2'b00;
    localparam logic [1:0] WB_MEM       = 2'b01;
    localparam logic [1:0] WB_PC4       = 2'b10;

    // Returns {valid, taken}; the ALU has just computed rs1 - rs2, so
    // signed less-than is negative XOR overflow.
    function automatic logic [1:0] branch_eval(input logic [2:0] funct3,
                                               input logic       zero,
                                               input logic       negative,
                                               input logic       overflow);
        logic       lt;
        logic [1:0] res;
        lt  = negative ^ overflow;
        res = 2'b00;
        case (funct3)
            F3_BEQ:  res = {1'b1, zero};
            F3_BNE:  res = {1'b1, ~zero};
            F3_BLT:  res = {1'b1, lt};
            F3_BGE:  res = {1'b1, ~lt};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// ALU operation decoder: maps funct3 (and funct7[5] for R-type) to the
// ALU select code, flagging combinations the datapath does not implement.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_is_rtype,
    output logic [2:0] o_alu_sel,
    output logic       o_valid
);

    // funct7[5] selects SUB only for R-type; I-type has no SUBI
    always_comb begin
        o_alu_sel = ALU_ADD;
        o_valid   = 1'b0;
        case (i_funct3)
            F3_ADD: begin
                o_valid   = 1'b1;
                o_alu_sel = (i_is_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
            end
            F3_SLT: begin
                o_valid   = 1'b1;
                o_alu_sel = ALU_SLT;
            end
            F3_OR: begin
                o_valid   = 1'b1;
                o_alu_sel = ALU_OR;
            end
            F3_AND: begin
                o_valid   = 1'b1;
                o_alu_sel = ALU_AND;
            end
            default: begin
                o_valid   = 1'b0;
                o_alu_sel = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 core. Sequences
// fetch/decode/execute/memory/writeback, drives ALU select and operand
// muxes, resolves branches from ALU flags and handshakes with the unified
// memory via mem_req/mem_ready.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_sel,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    state_t     r_state;
    // Low for the cycle following a reset edge: FETCH sits idle with all
    // strobes quiet so a reset during an access never leaves mem_req high
    // and a mem_ready still pending from the aborted access is ignored.
    logic       r_active;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7_5;
    logic [2:0] w_dec_sel;
    logic       w_dec_valid;
    logic [1:0] w_br;
    logic       w_br_valid;
    logic       w_br_taken;
    logic       w_unused_bits;

    assign w_opcode      = instr[6:0];
    assign w_funct3      = instr[14:12];
    assign w_funct7_5    = instr[30];
    assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign w_br       = branch_eval(w_funct3, zero, negative, overflow);
    assign w_br_valid = w_br[1];
    assign w_br_taken = w_br[0];

    alu_decoder u_alu_decoder (
        .i_funct3   (w_funct3),
        .i_funct7_5 (w_funct7_5),
        .i_is_rtype (r_state == ST_EXEC_R),
        .o_alu_sel  (w_dec_sel),
        .o_valid    (w_dec_valid)
    );

    // State register and next-state sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                ST_FETCH: begin
                    if (r_active && mem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (w_opcode)
                        OP_RTYPE:           r_state <= ST_EXEC_R;
                        OP_ITYPE:           r_state <= ST_EXEC_I;
                        OP_LOAD, OP_STORE:  r_state <= ST_MEM_ADDR;
                        OP_BRANCH:          r_state <= ST_BRANCH;
                        OP_JAL:             r_state <= ST_JAL;
                        default: begin
                            if (RESET_TRAP) r_state <= ST_TRAP;
                            else            r_state <= ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: begin
                    if (w_dec_valid)     r_state <= ST_ALU_WB;
                    else if (RESET_TRAP) r_state <= ST_TRAP;
                    else                 r_state <= ST_FETCH;
                end
                ST_ALU_WB:   r_state <= ST_FETCH;
                ST_MEM_ADDR: begin
                    if (w_opcode == OP_LOAD) r_state <= ST_MEM_RD;
                    else                     r_state <= ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    if (mem_ready) r_state <= ST_LD_WB;
                end
                ST_LD_WB:    r_state <= ST_FETCH;
                ST_MEM_WR: begin
                    if (mem_ready) r_state <= ST_FETCH;
                end
                ST_BRANCH: begin
                    if (!w_br_valid && RESET_TRAP) r_state <= ST_TRAP;
                    else                           r_state <= ST_FETCH;
                end
                ST_JAL:      r_state <= ST_FETCH;
                ST_TRAP:     r_state <= ST_TRAP;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    // Output decode from state; FETCH strobes and BRANCH pc_write also use inputs
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_sel       = ALU_ADD;
        reg_write     = 1'b0;
        mem_to_reg    = WB_ALUOUT;
        illegal_instr = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (r_active) begin
                    mem_req   = 1'b1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    alu_sel   = ALU_ADD;
                end
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                alu_sel   = ALU_ADD;
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_sel   = w_dec_sel;
            end
            ST_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_sel   = w_dec_sel;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_ALUOUT;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_sel   = ALU_ADD;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MEM;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_sel   = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = w_br_valid & w_br_taken;
            end
            ST_JAL: begin
                pc_src     = PC_SRC_ALUOUT;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = WB_PC4;
            end
            ST_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                illegal_instr = 1'b0;
            end
        endcase
    end

    assign state_o = r_state;

endmodule
